// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises a local Fibonacci LFSR to the incoming
// stream, then free-runs it and counts mismatching bits while locked.
module prbs_checker #(
  parameter int unsigned     W        = 12,
  parameter logic [W-1:0]    TAPS     = 12'h829,
  parameter int unsigned     LOCK_CNT = 16,
  parameter int unsigned     WIN      = 64,
  parameter int unsigned     ERR_TH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_bit,
  input  logic        in_valid,
  input  logic        clear,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_cnt,
  output logic [31:0] bit_cnt
);

  localparam int unsigned FILL_W  = $clog2(W + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned WIN_W   = $clog2(WIN + 1);
  localparam int unsigned ERR_W   = $clog2(ERR_TH + 1);

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         s_q, s_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [WIN_W-1:0]     win_bit_q, win_bit_d;
  logic [ERR_W-1:0]     win_err_q, win_err_d;
  logic                 locked_q, locked_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [15:0]          err_cnt_q, err_cnt_d;
  logic [31:0]          bit_cnt_q, bit_cnt_d;

  logic                 pred;
  logic                 mismatch;
  logic [MATCH_W-1:0]   match_inc;
  logic [ERR_W-1:0]     win_err_inc;

  // Prediction is taken from the register contents before this cycle's shift.
  always_comb begin
    pred        = ^(s_q & TAPS);
    mismatch    = in_bit ^ pred;
    match_inc   = match_q + MATCH_W'(1);
    win_err_inc = win_err_q + ERR_W'(mismatch);
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_bit_d   = win_bit_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;

    if (in_valid) begin
      unique case (state_q)
        ST_SEED: begin
          s_d = {s_q[W-2:0], in_bit};
          if (fill_q == FILL_W'(W - 1)) begin
            state_d = ST_VERIFY;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end

        ST_VERIFY: begin
          s_d = {s_q[W-2:0], in_bit};
          // An all-zero register predicts zeros forever; never trust it.
          if (s_q == '0) begin
            match_d = '0;
          end else if (!mismatch) begin
            if (match_inc == MATCH_W'(LOCK_CNT)) begin
              state_d   = ST_LOCKED;
              match_d   = '0;
              win_bit_d = '0;
              win_err_d = '0;
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d = '0;
          end
        end

        ST_LOCKED: begin
          s_d = {s_q[W-2:0], pred};
          if (bit_cnt_q != '1) begin
            bit_cnt_d = bit_cnt_q + 32'd1;
          end
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + 16'd1;
            end
          end
          // Threshold reached (early or at window end) drops lock.
          if (win_err_inc >= ERR_W'(ERR_TH)) begin
            state_d   = ST_SEED;
            fill_d    = '0;
            win_bit_d = '0;
            win_err_d = '0;
          end else if (win_bit_q == WIN_W'(WIN - 1)) begin
            win_bit_d = '0;
            win_err_d = '0;
          end else begin
            win_bit_d = win_bit_q + WIN_W'(1);
            win_err_d = win_err_inc;
          end
        end

        default: begin
          state_d = ST_SEED;
          fill_d  = '0;
        end
      endcase
    end

    if (clear) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SEED;
      s_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_bit_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_bit_q   <= win_bit_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker driven by a reference 12-bit Fibonacci LFSR.
module tb_prbs_checker;

  localparam logic [11:0] REF_TAPS = 12'h829;

  logic        clk;
  logic        rst;
  logic        in_bit;
  logic        in_valid;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [31:0] bit_cnt;

  int n_checks;
  int n_fail;
  logic [11:0] g;

  prbs_checker dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .bit_cnt   (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference generator: output bit is the tap parity, fed back into the LSB.
  task automatic next_gen(output logic b);
    b = ^(g & REF_TAPS);
    g = {g[10:0], b};
  endtask

  task automatic step(input logic b, input logic v, input logic c);
    in_bit   = b;
    in_valid = v;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_bit   = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0d expected 0", locked); end
    n_checks++;
    if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse: got %0d expected 0", err_pulse); end
    n_checks++;
    if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    n_checks++;
    if (bit_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt); end
  endtask

  task automatic test_clean_lock();
    logic b;
    g = 12'h001;
    for (int k = 1; k <= 28; k++) begin
      next_gen(b);
      step(b, 1'b1, 1'b0);
      if (k == 12 || k == 27) begin
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL clean_early_lock bit %0d: got %0d expected 0", k, locked); end
      end
    end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL clean_lock_at_28: got %0d expected 1", locked); end
    n_checks++;
    if (bit_cnt !== 32'd0) begin n_fail++; $display("FAIL clean_bit_cnt_at_lock: got %0d expected 0", bit_cnt); end
    for (int k = 0; k < 1000; k++) begin
      next_gen(b);
      step(b, 1'b1, 1'b0);
      n_checks++;
      if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL clean_err_pulse bit %0d: got %0d expected 0", k, err_pulse); end
    end
    n_checks++;
    if (bit_cnt !== 32'd1000) begin n_fail++; $display("FAIL clean_bit_cnt: got %0d expected 1000", bit_cnt); end
    n_checks++;
    if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL clean_err_cnt: got %0d expected 0", err_cnt); end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL clean_still_locked: got %0d expected 1", locked); end
  endtask

  task automatic test_single_error();
    logic b;
    next_gen(b);
    step(~b, 1'b1, 1'b0);
    n_checks++;
    if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL single_err_pulse: got %0d expected 1", err_pulse); end
    n_checks++;
    if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL single_err_cnt: got %0d expected 1", err_cnt); end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL single_locked: got %0d expected 1", locked); end
    n_checks++;
    if (bit_cnt !== 32'd1001) begin n_fail++; $display("FAIL single_bit_cnt: got %0d expected 1001", bit_cnt); end
    for (int k = 0; k < 3; k++) begin
      next_gen(b);
      step(b, 1'b1, 1'b0);
      n_checks++;
      if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL single_no_propagation bit %0d: got %0d expected 0", k, err_pulse); end
    end
    n_checks++;
    if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL single_err_cnt_after: got %0d expected 1", err_cnt); end
  endtask

  task automatic test_clear_with_error();
    logic b;
    next_gen(b);
    step(~b, 1'b1, 1'b1);
    n_checks++;
    if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL clear_err_cnt: got %0d expected 0", err_cnt); end
    n_checks++;
    if (bit_cnt !== 32'd0) begin n_fail++; $display("FAIL clear_bit_cnt: got %0d expected 0", bit_cnt); end
    n_checks++;
    if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL clear_err_pulse: got %0d expected 1", err_pulse); end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL clear_locked: got %0d expected 1", locked); end
  endtask

  task automatic test_reset_mid_lock();
    logic b;
    next_gen(b);
    step(~b, 1'b1, 1'b0);
    n_checks++;
    if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL midrst_pre_err_cnt: got %0d expected 1", err_cnt); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL midrst_locked: got %0d expected 0", locked); end
    n_checks++;
    if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_err_cnt: got %0d expected 0", err_cnt); end
    n_checks++;
    if (bit_cnt !== 32'd0) begin n_fail++; $display("FAIL midrst_bit_cnt: got %0d expected 0", bit_cnt); end
    n_checks++;
    if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL midrst_err_pulse: got %0d expected 0", err_pulse); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_loss_of_lock();
    logic b;
    apply_reset();
    for (int k = 1; k <= 28; k++) begin
      next_gen(b);
      step(b, 1'b1, 1'b0);
    end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_initial_lock: got %0d expected 1", locked); end
    for (int k = 1; k <= 8; k++) begin
      next_gen(b);
      step(~b, 1'b1, 1'b0);
      n_checks++;
      if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL loss_err_pulse err %0d: got %0d expected 1", k, err_pulse); end
      n_checks++;
      if (locked !== (k < 8)) begin n_fail++; $display("FAIL loss_locked err %0d: got %0d expected %0d", k, locked, (k < 8)); end
    end
    n_checks++;
    if (err_cnt !== 16'd8) begin n_fail++; $display("FAIL loss_err_cnt: got %0d expected 8", err_cnt); end
    for (int k = 1; k <= 28; k++) begin
      next_gen(b);
      step(b, 1'b1, 1'b0);
      if (k == 27) begin
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early: got %0d expected 0", locked); end
      end
    end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL relock_at_28: got %0d expected 1", locked); end
    n_checks++;
    if (err_cnt !== 16'd8) begin n_fail++; $display("FAIL relock_err_cnt_kept: got %0d expected 8", err_cnt); end
    n_checks++;
    if (bit_cnt !== 32'd8) begin n_fail++; $display("FAIL relock_bit_cnt_kept: got %0d expected 8", bit_cnt); end
  endtask

  task automatic test_gapped_valid();
    logic b;
    logic [31:0] cnt_before;
    apply_reset();
    for (int k = 1; k <= 28; k++) begin
      next_gen(b);
      step(b, 1'b1, 1'b0);
      step(~b, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      if (k == 27) begin
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL gapped_early_lock: got %0d expected 0", locked); end
      end
    end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL gapped_lock_at_28_valid: got %0d expected 1", locked); end
    for (int k = 1; k <= 10; k++) begin
      next_gen(b);
      step(b, 1'b1, 1'b0);
      n_checks++;
      if (bit_cnt !== 32'(k)) begin n_fail++; $display("FAIL gapped_bit_cnt valid %0d: got %0d expected %0d", k, bit_cnt, k); end
      cnt_before = bit_cnt;
      step(~b, 1'b0, 1'b0);
      step(b, 1'b0, 1'b0);
      n_checks++;
      if (bit_cnt !== cnt_before) begin n_fail++; $display("FAIL gapped_bit_cnt_hold %0d: got %0d expected %0d", k, bit_cnt, cnt_before); end
      n_checks++;
      if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL gapped_err_pulse %0d: got %0d expected 0", k, err_pulse); end
    end
    n_checks++;
    if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL gapped_err_cnt: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_all_zero();
    apply_reset();
    for (int k = 0; k < 200; k++) begin
      step(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (locked !== 1'b0) begin n_fail++; $display("FAIL zero_locked bit %0d: got %0d expected 0", k, locked); end
    end
    n_checks++;
    if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL zero_err_cnt: got %0d expected 0", err_cnt); end
    n_checks++;
    if (bit_cnt !== 32'd0) begin n_fail++; $display("FAIL zero_bit_cnt: got %0d expected 0", bit_cnt); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    g        = 12'h001;
    rst      = 1'b1;
    in_bit   = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    test_reset();
    test_clean_lock();
    test_single_error();
    test_clear_with_error();
    test_reset_mid_lock();
    test_loss_of_lock();
    test_gapped_valid();
    test_all_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Serial PRBS receiver/checker. It is the receive-end counterpart of the LFSR noise generators that feed noise1..noise3.
- It takes a bit stream with a valid strobe, self-synchronises a local LFSR to the stream, then free-runs that LFSR and counts mismatching bits.
- It drives lock status, error counters and a per-bit error pulse for on-board display (Seg) and for bench checking of generator outputs.

Parameters:
- W, 12, LFSR length in bits (2..32).
- TAPS, 12'h829, feedback mask. Predicted bit = XOR of s[i] for every i with TAPS[i]=1. Default is x^12+x^6+x^4+x+1.
- LOCK_CNT, 16, consecutive matches required to declare lock (1..255).
- WIN, 64, bits per loss-of-lock evaluation window (2..65535).
- ERR_TH, 8, errors within one window that force loss of lock (1..WIN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_bit  in  1  received PRBS bit.
- in_valid  in  1  in_bit is sampled on clk rising edge when high.
- clear  in  1  synchronous clear of err_cnt and bit_cnt. Does not affect lock state.
- locked  out  1  checker is synchronised.
- err_pulse  out  1  one-cycle pulse per mismatched bit while LOCKED.
- err_cnt  out  16  saturating count of mismatches while LOCKED.
- bit_cnt  out  32  saturating count of bits checked while LOCKED.

Behaviour:
- Reset (async, active-high): state=SEED, s=0, fill counter=0, match counter=0, window counters=0. Outputs locked=0, err_pulse=0, err_cnt=0, bit_cnt=0.
- LFSR shift: s <= {s[W-2:0], b}, where b is the bit shifted in. p = ^(s & TAPS) is evaluated on s before the shift. Nothing advances on a cycle with in_valid=0. err_pulse is 0 on those cycles.
- SEED:
  - Each valid bit is shifted in with b=in_bit; the fill counter increments.
  - After W valid bits, go to VERIFY with match counter=0.
- VERIFY:
  - Each valid bit: b=in_bit (self-synchronising).
  - If s==0 (lockup pattern), no match is counted and the match counter is cleared.
  - Else if in_bit==p, the match counter increments; else the match counter is cleared.
  - When the match counter reaches LOCK_CNT, go to LOCKED. locked=1 from the next cycle. Window counters are cleared on entry.
  - No errors are counted in SEED or VERIFY.
- LOCKED:
  - Each valid bit: b=p (free-running, so errors do not propagate).
  - bit_cnt increments, saturating at 32'hFFFF_FFFF.
  - If in_bit!=p: err_pulse=1 on the next cycle, err_cnt increments (saturating at 16'hFFFF), window error counter increments.
  - Window bit counter counts to WIN. At the WIN-th bit, the window error count (including that bit) is compared to ERR_TH:
    - If >= ERR_TH, go to SEED: locked=0 next cycle, fill counter=0.
    - Either way, both window counters reset.
  - If the window error count reaches ERR_TH before the window ends, drop lock immediately (same transition).
- clear and a count increment in the same cycle: clear wins, so the counter reads 0.
- Counters hold their values across loss and regain of lock; only clear or rst zeroes them.
- Reset asserted mid-stream returns to SEED within the same cycle (async). The first valid bit after reset release is fill bit 0.
- All outputs are registered. Latency from the in_valid sampling edge to the locked/err_pulse/counter update is one clock.

Test Plan:
- Clean stream: a reference 12-bit Fibonacci LFSR (TAPS 12'h829, seed 12'h001) feeds in_valid=1 every cycle. Required: locked rises after exactly W+LOCK_CNT=28 valid bits. After 1000 further bits: bit_cnt=1000, err_cnt=0, err_pulse never high.
- Single error: while locked, invert one bit. Required: exactly one err_pulse one cycle later, err_cnt=1, locked stays 1, and the next bit matches (no propagation).
- Loss of lock: while locked, invert 8 bits within one 64-bit window. Required: locked=0 one cycle after the 8th error. Then re-lock after 28 further clean bits; err_cnt=8 is retained.
- Gapped valid: the clean stream with in_valid toggling 1,0,0,1,... Required: lock is reached after 28 valid bits (not 28 cycles), and no counter moves on invalid cycles.
- All-zero input: 200 zero bits. Required: locked stays 0 (lockup guard); err_cnt=0.
- Reset mid-lock plus clear: assert rst asynchronously between edges. Required: locked, err_cnt and bit_cnt are 0 immediately. Separately, clear while locked with an error in the same cycle gives err_cnt=0.
